// File: rtl/axi_stream_packet_sink_if.sv
// AXI4-Stream link bundle: clock, reset and one beat channel.
// The sink binds to the slave modport; a packet source to the master.
interface axi_stream_if;
  typedef logic [31:0] data_t;

  logic  aclk;
  logic  areset_n;
  logic  tvalid;
  logic  tready;
  data_t tdata;
  logic  tlast;

  modport slave (
    input  aclk,
    input  areset_n,
    input  tvalid,
    input  tdata,
    input  tlast,
    output tready
  );

  modport master (
    input  aclk,
    input  areset_n,
    input  tready,
    output tvalid,
    output tdata,
    output tlast
  );
endinterface

// File: rtl/axi_stream_packet_sink.sv
// AXI4-Stream packet sink: FWFT FIFO plus length and pattern checker.
// Saturating counters report good packets, length and data errors.
module axi_stream_packet_sink #(
  parameter int          DEPTH      = 16,
  parameter int          PKT_LEN    = 9,
  parameter logic [31:0] DATA_BASE  = 32'hdeadbeef,
  parameter bit          CHECK_DATA = 1'b1
) (
  axi_stream_if.slave               s_axi_stream,
  input  logic                      rd_en,
  output logic                      rd_valid,
  output logic [31:0]               rd_data,
  output logic                      rd_last,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic [15:0]               pkt_count,
  output logic [15:0]               len_err_count,
  output logic [15:0]               data_err_count,
  output logic                      busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(PKT_LEN - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RECV    = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  logic          clk;
  logic          rst_n;
  logic [1:0]    state;
  logic [IW-1:0] beat_idx;
  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          accept;
  logic          push;
  logic          pop;
  logic          at_last;
  logic          data_bad;

  assign clk   = s_axi_stream.aclk;
  assign rst_n = s_axi_stream.areset_n;

  assign full     = (fifo_level == FULL_LVL);
  assign rd_valid = (fifo_level != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr][31:0] : 32'd0;
  assign rd_last  = rd_valid & mem[rd_ptr][32];
  assign busy     = (state != IDLE);

  // Held low in reset; the tail of an overrun packet is always drained.
  assign s_axi_stream.tready =
    rst_n & ((state == DISCARD) | ~full);

  assign accept = s_axi_stream.tvalid & s_axi_stream.tready;
  assign push   = accept & (state != DISCARD);
  assign pop    = rd_en & rd_valid;

  assign at_last  = (beat_idx == LAST_IDX);
  assign data_bad = CHECK_DATA &&
    (s_axi_stream.tdata != DATA_BASE + 32'(beat_idx));

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {s_axi_stream.tlast, s_axi_stream.tdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        fifo_level <= fifo_level + 1'b1;
      else if (pop && !push)
        fifo_level <= fifo_level - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      beat_idx       <= '0;
      pkt_count      <= '0;
      len_err_count  <= '0;
      data_err_count <= '0;
    end else if (accept) begin
      if (state == DISCARD) begin
        if (s_axi_stream.tlast) begin
          beat_idx <= '0;
          state    <= IDLE;
        end
      end else begin
        if (data_bad)
          data_err_count <= sat_inc(data_err_count);
        unique case (1'b1)
          s_axi_stream.tlast && at_last: begin
            pkt_count <= sat_inc(pkt_count);
            beat_idx  <= '0;
            state     <= IDLE;
          end
          s_axi_stream.tlast && !at_last: begin
            len_err_count <= sat_inc(len_err_count);
            beat_idx      <= '0;
            state         <= IDLE;
          end
          !s_axi_stream.tlast && !at_last: begin
            beat_idx <= beat_idx + 1'b1;
            state    <= RECV;
          end
          default: begin
            len_err_count <= sat_inc(len_err_count);
            state         <= DISCARD;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axi_stream_packet_sink.sv
// Directed bench for axi_stream_packet_sink with default parameters.
// Each scenario starts from a fresh reset.
module tb_axi_stream_packet_sink;

  localparam logic [31:0] BASE = 32'hdeadbeef;

  axi_stream_if bus ();

  logic        rd_en;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_last;
  logic [4:0]  fifo_level;
  logic [15:0] pkt_count;
  logic [15:0] len_err_count;
  logic [15:0] data_err_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  axi_stream_packet_sink dut (
    .s_axi_stream   (bus.slave),
    .rd_en          (rd_en),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .rd_last        (rd_last),
    .fifo_level     (fifo_level),
    .pkt_count      (pkt_count),
    .len_err_count  (len_err_count),
    .data_err_count (data_err_count),
    .busy           (busy)
  );

  initial bus.aclk = 1'b0;
  always #5 bus.aclk = ~bus.aclk;

  task automatic do_reset();
    bus.areset_n = 1'b0;
    bus.tvalid   = 1'b0;
    bus.tdata    = '0;
    bus.tlast    = 1'b0;
    rd_en        = 1'b0;
    repeat (2) @(negedge bus.aclk);
    bus.areset_n = 1'b1;
    @(negedge bus.aclk);
  endtask

  // Drive one beat from a negedge and hold it until accepted.
  task automatic send(input logic [31:0] d, input logic l);
    bit ok = 0;
    bus.tvalid = 1'b1;
    bus.tdata  = d;
    bus.tlast  = l;
    for (int k = 0; k < 50; k++) begin
      if (bus.tready) begin
        @(negedge bus.aclk);
        ok = 1;
        break;
      end
      @(negedge bus.aclk);
    end
    bus.tvalid = 1'b0;
    bus.tlast  = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout data=%h never accepted", d);
    end
  endtask

  task automatic send_seq(input int n, input int last_at,
                          input int bad_at);
    for (int i = 0; i < n; i++)
      send((i == bad_at) ? 32'd0 : BASE + 32'(i), i == last_at);
  endtask

  task automatic check_counts(input string tag, input int lvl,
                              input int pk, input int le,
                              input int de, input logic bz);
    checks++;
    if (fifo_level !== 5'(lvl) || pkt_count !== 16'(pk) ||
        len_err_count !== 16'(le) || data_err_count !== 16'(de) ||
        busy !== bz) begin
      errors++;
      $display("FAIL %s got lvl=%0d pkt=%0d len=%0d dat=%0d busy=%b want lvl=%0d pkt=%0d len=%0d dat=%0d busy=%b",
               tag, fifo_level, pkt_count, len_err_count,
               data_err_count, busy, lvl, pk, le, de, bz);
    end
  endtask

  task automatic test_reset();
    bus.areset_n = 1'b0;
    bus.tvalid   = 1'b1;
    bus.tdata    = BASE;
    bus.tlast    = 1'b0;
    rd_en        = 1'b0;
    repeat (2) @(negedge bus.aclk);
    checks++;
    if (bus.tready !== 1'b0 || rd_valid !== 1'b0 ||
        rd_last !== 1'b0 || rd_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs got tready=%b rd_valid=%b rd_last=%b rd_data=%h want 0",
               bus.tready, rd_valid, rd_last, rd_data);
    end
    check_counts("reset_counts", 0, 0, 0, 0, 1'b0);
    do_reset();
  endtask

  task automatic test_good_packet();
    do_reset();
    send_seq(9, 8, -1);
    check_counts("good_pkt", 9, 1, 0, 0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== BASE + 32'(i) ||
          rd_last !== (i == 8)) begin
        errors++;
        $display("FAIL replay_%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 i, rd_valid, rd_data, rd_last, BASE + 32'(i),
                 i == 8);
      end
      rd_en = 1'b1;
      @(negedge bus.aclk);
      rd_en = 1'b0;
    end
    checks++;
    if (rd_valid !== 1'b0 || fifo_level !== 5'd0) begin
      errors++;
      $display("FAIL replay_empty got v=%b lvl=%0d want v=0 lvl=0",
               rd_valid, fifo_level);
    end
  endtask

  task automatic test_full_and_pop();
    do_reset();
    send_seq(9, 8, -1);
    send_seq(7, -1, -1);
    check_counts("full_level", 16, 1, 0, 0, 1'b1);
    bus.tvalid = 1'b1;
    bus.tdata  = BASE + 32'd7;
    bus.tlast  = 1'b0;
    repeat (3) @(negedge bus.aclk);
    checks++;
    if (bus.tready !== 1'b0 || fifo_level !== 5'd16) begin
      errors++;
      $display("FAIL full_block got tready=%b lvl=%0d want tready=0 lvl=16",
               bus.tready, fifo_level);
    end
    rd_en = 1'b1;
    @(negedge bus.aclk);
    rd_en = 1'b0;
    checks++;
    if (fifo_level !== 5'd15 || bus.tready !== 1'b1 ||
        rd_data !== BASE + 32'd1) begin
      errors++;
      $display("FAIL full_pop_only got lvl=%0d tready=%b head=%h want lvl=15 tready=1 head=%h",
               fifo_level, bus.tready, rd_data, BASE + 32'd1);
    end
    @(negedge bus.aclk);
    checks++;
    if (fifo_level !== 5'd16 || bus.tready !== 1'b0) begin
      errors++;
      $display("FAIL full_one_more got lvl=%0d tready=%b want lvl=16 tready=0",
               fifo_level, bus.tready);
    end
    @(negedge bus.aclk);
    bus.tvalid = 1'b0;
    check_counts("full_hold", 16, 1, 0, 0, 1'b1);
  endtask

  task automatic test_short_packet();
    do_reset();
    send_seq(5, 4, -1);
    check_counts("short_pkt", 5, 0, 1, 0, 1'b0);
  endtask

  task automatic test_long_packet();
    do_reset();
    send_seq(10, -1, -1);
    check_counts("long_discard", 9, 0, 1, 0, 1'b1);
    send(32'd0, 1'b0);
    send(32'h1234, 1'b1);
    check_counts("long_pkt", 9, 0, 1, 0, 1'b0);
  endtask

  task automatic test_data_error();
    do_reset();
    send_seq(9, 8, 3);
    check_counts("data_err", 9, 1, 0, 1, 1'b0);
  endtask

  task automatic test_reset_midpacket();
    do_reset();
    send_seq(5, -1, 1);
    check_counts("pre_reset", 5, 0, 0, 1, 1'b1);
    bus.areset_n = 1'b0;
    #1;
    checks++;
    if (fifo_level !== 5'd0 || bus.tready !== 1'b0 ||
        busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got lvl=%0d tready=%b busy=%b want 0 0 0",
               fifo_level, bus.tready, busy);
    end
    @(negedge bus.aclk);
    bus.areset_n = 1'b1;
    @(negedge bus.aclk);
    check_counts("post_reset", 0, 0, 0, 0, 1'b0);
    send_seq(9, 8, -1);
    check_counts("post_reset_pkt", 9, 1, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_seq(5, 4, -1);
    send_seq(9, 8, -1);
    check_counts("b2b", 14, 1, 1, 0, 1'b0);
  endtask

  initial begin
    bus.areset_n = 1'b0;
    bus.tvalid   = 1'b0;
    bus.tdata    = '0;
    bus.tlast    = 1'b0;
    rd_en        = 1'b0;
    test_reset();
    test_good_packet();
    test_full_and_pop();
    test_short_packet();
    test_long_packet();
    test_data_error();
    test_reset_midpacket();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
